// File: rtl/gpioemu_pkg.sv
// gpioemu_pkg: shared definitions for the gpioemu bus initiator and its bench
// model. Holds the peripheral address map, STATUS/CTRL bit layout, the job FSM
// state encoding, and the bus-phase encoding used by the access sequencer.
package gpioemu_pkg;

  // Peripheral register map
  localparam logic [15:0] ADDR_A1     = 16'h0370;
  localparam logic [15:0] ADDR_A2     = 16'h0378;
  localparam logic [15:0] ADDR_RESULT = 16'h0390;
  localparam logic [15:0] ADDR_ONES   = 16'h0398;
  localparam logic [15:0] ADDR_CTRL   = 16'h03A0;
  localparam logic [15:0] ADDR_STATUS = ADDR_CTRL;  // same register, read side

  // STATUS read bits and CTRL write value
  localparam int          STAT_BUSY_BIT = 0;
  localparam int          STAT_DONE_BIT = 1;
  localparam logic [31:0] CTRL_START    = 32'h0000_0001;

  // Job-level FSM
  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_A1,
    S_WR_A2,
    S_WR_START,
    S_POLL,
    S_TIMEOUT,
    S_RD_RES,
    S_RD_ONES,
    S_RESP
  } job_state_e;

  // Single-access bus phases
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } bus_phase_e;

  // Operands are 24 bits; the bus carries 32.
  function automatic logic [31:0] zext24(input logic [23:0] v);
    return {8'h00, v};
  endfunction

endpackage

// File: rtl/gpioemu_bus_phy.sv
// gpioemu_bus_phy: sequencer for one gpioemu bus access.
// A request (req, rd_nwr, addr, wdata) is taken while idle; the access then
// runs SETUP_CYC cycles with address/data stable and strobes low, STROBE_CYC
// cycles with srd or swr high, and HOLD_CYC cycles with strobes low and
// address/data still held. done pulses for one cycle after the hold phase,
// with rdata valid for reads. Between accesses saddress and sdata_wr are 0.
// Ports:
//   clk, n_reset          clock, async active-low reset
//   req/rd_nwr/addr/wdata access request (held by the caller until done)
//   done, rdata           completion pulse and captured read data
//   saddress/srd/swr/sdata_wr/sdata_rd  peripheral bus
module gpioemu_bus_phy
  import gpioemu_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req,
  input  logic        rd_nwr,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd
);

  bus_phase_e  phase_q, phase_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        srd_q, srd_d;
  logic        swr_q, swr_d;
  logic        done_q, done_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    phase_d = phase_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    srd_d   = srd_q;
    swr_d   = swr_q;
    done_d  = 1'b0;
    unique case (phase_q)
      PH_IDLE: begin
        // The cycle carrying done is skipped so the caller can move on to its
        // next request before a new access starts.
        if (req && !done_q) begin
          addr_d  = addr;
          wdata_d = rd_nwr ? 32'h0 : wdata;
          rd_d    = rd_nwr;
          cnt_d   = 8'd0;
          phase_d = PH_SETUP;
        end
      end
      PH_SETUP: begin
        if (cnt_q == 8'(SETUP_CYC - 1)) begin
          cnt_d   = 8'd0;
          srd_d   = rd_q;
          swr_d   = !rd_q;
          phase_d = PH_STROBE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PH_STROBE: begin
        if (cnt_q == 8'(STROBE_CYC - 1)) begin
          cnt_d   = 8'd0;
          srd_d   = 1'b0;
          swr_d   = 1'b0;
          // Sampled at the edge that closes the last strobe-high cycle.
          if (rd_q) rdata_d = sdata_rd;
          phase_d = PH_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PH_HOLD: begin
        if (cnt_q == 8'(HOLD_CYC - 1)) begin
          cnt_d   = 8'd0;
          addr_d  = 16'h0;
          wdata_d = 32'h0;
          done_d  = 1'b1;
          phase_d = PH_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase_q <= PH_IDLE;
      cnt_q   <= 8'd0;
      rd_q    <= 1'b0;
      addr_q  <= 16'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      srd_q   <= 1'b0;
      swr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      srd_q   <= srd_d;
      swr_q   <= swr_d;
      done_q  <= done_d;
    end
  end

  assign saddress = addr_q;
  assign sdata_wr = wdata_q;
  assign srd      = srd_q;
  assign swr      = swr_q;
  assign done     = done_q;
  assign rdata    = rdata_q;

endmodule

// File: rtl/gpioemu_bus_master.sv
// gpioemu_bus_master: CPU-side initiator for the gpioemu multiply unit.
// Takes one job (A1, A2) on the cmd valid/ready port, writes both operands,
// writes CTRL start, polls STATUS until done (or gives up after POLL_MAX
// reads), reads RESULT and ONES, and presents them on the rsp valid/ready port.
// Ports:
//   clk, n_reset                    clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_a1/a2   job request (ready only while idle)
//   rsp_valid/rsp_ready             response handshake
//   rsp_result/rsp_ones/rsp_timeout response fields, zero after handshake
//   busy                            job accepted and response not yet taken
//   saddress/srd/swr/sdata_wr/sdata_rd  peripheral bus
module gpioemu_bus_master
  import gpioemu_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned POLL_MAX   = 255
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a1,
  input  logic [23:0] cmd_a2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [23:0] rsp_ones,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd
);

  job_state_e  state_q, state_d;
  logic [23:0] a1_q, a1_d, a2_q, a2_d;
  logic [7:0]  polls_q, polls_d;
  logic [31:0] result_q, result_d;
  logic [23:0] ones_q, ones_d;
  logic        timeout_q, timeout_d;
  logic        ready_q, busy_q;

  logic        phy_req, phy_rd, phy_done;
  logic [15:0] phy_addr;
  logic [31:0] phy_wdata, phy_rdata;

  gpioemu_bus_phy #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_phy (
    .clk     (clk),
    .n_reset (n_reset),
    .req     (phy_req),
    .rd_nwr  (phy_rd),
    .addr    (phy_addr),
    .wdata   (phy_wdata),
    .done    (phy_done),
    .rdata   (phy_rdata),
    .saddress(saddress),
    .srd     (srd),
    .swr     (swr),
    .sdata_wr(sdata_wr),
    .sdata_rd(sdata_rd)
  );

  always_comb begin
    state_d   = state_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    polls_d   = polls_q;
    result_d  = result_q;
    ones_d    = ones_q;
    timeout_d = timeout_q;
    phy_req   = 1'b0;
    phy_rd    = 1'b0;
    phy_addr  = 16'h0;
    phy_wdata = 32'h0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          a1_d      = cmd_a1;
          a2_d      = cmd_a2;
          polls_d   = 8'd0;
          result_d  = 32'h0;
          ones_d    = 24'h0;
          timeout_d = 1'b0;
          state_d   = S_WR_A1;
        end
      end
      S_WR_A1: begin
        phy_req   = 1'b1;
        phy_addr  = ADDR_A1;
        phy_wdata = zext24(a1_q);
        if (phy_done) state_d = S_WR_A2;
      end
      S_WR_A2: begin
        phy_req   = 1'b1;
        phy_addr  = ADDR_A2;
        phy_wdata = zext24(a2_q);
        if (phy_done) state_d = S_WR_START;
      end
      S_WR_START: begin
        phy_req   = 1'b1;
        phy_addr  = ADDR_CTRL;
        phy_wdata = CTRL_START;
        if (phy_done) state_d = S_POLL;
      end
      S_POLL: begin
        phy_req  = 1'b1;
        phy_rd   = 1'b1;
        phy_addr = ADDR_STATUS;
        if (phy_done) begin
          polls_d = polls_q + 8'd1;
          // done wins even on the final permitted poll
          if (phy_rdata[STAT_DONE_BIT])       state_d = S_RD_RES;
          else if (polls_d == 8'(POLL_MAX))   state_d = S_TIMEOUT;
        end
      end
      S_TIMEOUT: begin
        timeout_d = 1'b1;
        result_d  = 32'h0;
        ones_d    = 24'h0;
        state_d   = S_RESP;
      end
      S_RD_RES: begin
        phy_req  = 1'b1;
        phy_rd   = 1'b1;
        phy_addr = ADDR_RESULT;
        if (phy_done) begin
          result_d = phy_rdata;
          state_d  = S_RD_ONES;
        end
      end
      S_RD_ONES: begin
        phy_req  = 1'b1;
        phy_rd   = 1'b1;
        phy_addr = ADDR_ONES;
        if (phy_done) begin
          ones_d  = phy_rdata[23:0];
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          result_d  = 32'h0;
          ones_d    = 24'h0;
          timeout_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      a1_q      <= 24'h0;
      a2_q      <= 24'h0;
      polls_q   <= 8'd0;
      result_q  <= 32'h0;
      ones_q    <= 24'h0;
      timeout_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      polls_q   <= polls_d;
      result_q  <= result_d;
      ones_q    <= ones_d;
      timeout_q <= timeout_d;
      // Registered from the next state so both read 0 throughout reset and
      // cmd_ready only rises on the first clock after release.
      ready_q   <= (state_d == S_IDLE);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign cmd_ready   = ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_result  = result_q;
  assign rsp_ones    = ones_q;
  assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_gpioemu_bus_master.sv
// Directed bench for gpioemu_bus_master with a small gpioemu peripheral model
// and a bus monitor that checks access timing and logs completed accesses.
module tb_gpioemu_bus_master;
  import gpioemu_pkg::*;

  localparam int unsigned SETUP_CYC  = 1;
  localparam int unsigned STROBE_CYC = 2;
  localparam int unsigned HOLD_CYC   = 1;
  localparam int unsigned POLL_MAX   = 4;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [23:0] cmd_a1 = 24'h0, cmd_a2 = 24'h0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [23:0] rsp_ones;
  logic        rsp_timeout, busy;
  logic [15:0] saddress;
  logic        srd, swr;
  logic [31:0] sdata_wr, sdata_rd;

  always #5 clk = ~clk;

  gpioemu_bus_master #(
    .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC(HOLD_CYC),   .POLL_MAX(POLL_MAX)
  ) dut (
    .clk(clk), .n_reset(n_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a1(cmd_a1), .cmd_a2(cmd_a2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_ones(rsp_ones), .rsp_timeout(rsp_timeout), .busy(busy),
    .saddress(saddress), .srd(srd), .swr(swr), .sdata_wr(sdata_wr), .sdata_rd(sdata_rd)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- peripheral model ----------------
  logic [23:0] m_a1 = 24'h0, m_a2 = 24'h0;
  logic [31:0] m_result = 32'h0;
  logic [23:0] m_ones = 24'h0;
  int          m_done_after = 0;   // 0: never reports done
  int          m_stat_cnt = 0;     // completed STATUS reads since start
  logic        m_done;

  always_comb begin
    m_done = (m_done_after != 0) && (m_stat_cnt + 1 >= m_done_after);
    sdata_rd = 32'hDEAD_BEEF;
    case (saddress)
      ADDR_RESULT: sdata_rd = m_result;
      ADDR_ONES:   sdata_rd = {8'hA5, m_ones};   // upper byte must be dropped
      ADDR_STATUS: begin
        sdata_rd = 32'h0;
        sdata_rd[STAT_DONE_BIT] = m_done;
        sdata_rd[STAT_BUSY_BIT] = !m_done;
      end
      default: sdata_rd = 32'hDEAD_BEEF;
    endcase
  end

  // ---------------- bus monitor ----------------
  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [31:0] data;
  } acc_t;

  acc_t log_q[$];
  acc_t exp_q[$];

  logic        mon_active = 1'b0;
  int          mon_setup, mon_strobe, mon_hold;
  acc_t        mon_acc;
  logic [31:0] mon_wdata;
  logic [47:0] mon_prod;

  always @(negedge clk) begin
    assert (!(srd && swr));
    if (!n_reset) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && saddress != 16'h0) begin
        mon_active = 1'b1;
        mon_setup = 0; mon_strobe = 0; mon_hold = 0;
        mon_acc.rd = 1'b0; mon_acc.addr = saddress; mon_acc.data = sdata_wr;
        mon_wdata = sdata_wr;
      end
      if (mon_active) begin
        if (saddress == 16'h0) begin
          check("setup_cyc",  32'(mon_setup),  SETUP_CYC);
          check("strobe_cyc", 32'(mon_strobe), STROBE_CYC);
          check("hold_cyc",   32'(mon_hold),   HOLD_CYC);
          check("idle_wdata", sdata_wr, 32'h0);
          if (!mon_acc.rd) begin
            if (mon_acc.addr == ADDR_A1) m_a1 = mon_acc.data[23:0];
            if (mon_acc.addr == ADDR_A2) m_a2 = mon_acc.data[23:0];
            if (mon_acc.addr == ADDR_CTRL && mon_acc.data[0]) begin
              mon_prod   = m_a1 * m_a2;
              m_result   = mon_prod[31:0];
              m_ones     = 24'($countones(mon_prod));
              m_stat_cnt = 0;
            end
          end else if (mon_acc.addr == ADDR_STATUS) begin
            m_stat_cnt++;
          end
          log_q.push_back(mon_acc);
          mon_active = 1'b0;
        end else begin
          check("addr_held",  {16'h0, saddress}, {16'h0, mon_acc.addr});
          check("wdata_held", sdata_wr, mon_wdata);
          if (srd || swr) begin
            mon_strobe++;
            check("strobe_excl", 32'(srd && swr), 32'h0);
            if (srd) begin
              mon_acc.rd = 1'b1;
              mon_acc.data = sdata_rd;
            end
          end else if (mon_strobe == 0) begin
            mon_setup++;
          end else begin
            mon_hold++;
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic exp_w(input logic [15:0] a, input logic [31:0] d);
    acc_t e;
    e.rd = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_r(input logic [15:0] a);
    acc_t e;
    e.rd = 1'b1; e.addr = a; e.data = 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_nacc"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), {16'h0, log_q[i].addr}, {16'h0, exp_q[i].addr});
      check($sformatf("%s_dir%0d", tag, i), 32'(log_q[i].rd), 32'(exp_q[i].rd));
      if (!exp_q[i].rd)
        check($sformatf("%s_wdat%0d", tag, i), log_q[i].data, exp_q[i].data);
    end
    exp_q.delete();
  endtask

  // Called at a negedge with the DUT idle.
  task automatic send_cmd(input string tag, input logic [23:0] a1, input logic [23:0] a2);
    int n;
    cmd_a1 = a1; cmd_a2 = a2; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a1 = 24'hBAD0BA; cmd_a2 = 24'h0BAD0B;   // must not leak into the job
    check({tag, "_busy"}, 32'(busy), 32'h1);
    check({tag, "_ready_low"}, 32'(cmd_ready), 32'h0);
  endtask

  task automatic do_job(input string tag, input logic [23:0] a1, input logic [23:0] a2,
                        input int done_after, input int hold_cycles,
                        input logic [31:0] e_res, input logic [23:0] e_ones, input logic e_to);
    int n;
    logic [31:0] seen_res;
    m_done_after = done_after;
    log_q.delete();
    send_cmd(tag, a1, a2);
    n = 0;
    while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
    check({tag, "_result"},  rsp_result, e_res);
    check({tag, "_ones"},    {8'h0, rsp_ones}, {8'h0, e_ones});
    check({tag, "_timeout"}, 32'(rsp_timeout), 32'(e_to));
    seen_res = rsp_result;
    for (int i = 0; i < hold_cycles; i++) begin
      cmd_valid = 1'b1; cmd_a1 = 24'h000055; cmd_a2 = 24'h000077;
      @(negedge clk);
      check({tag, "_hold_valid"},  32'(rsp_valid), 32'h1);
      check({tag, "_hold_result"}, rsp_result, seen_res);
      check({tag, "_hold_ready"},  32'(cmd_ready), 32'h0);
      check({tag, "_hold_bus"},    {14'h0, srd, swr, saddress}, 32'h0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_post_valid"},  32'(rsp_valid), 32'h0);
    check({tag, "_post_ready"},  32'(cmd_ready), 32'h1);
    check({tag, "_post_busy"},   32'(busy), 32'h0);
    check({tag, "_post_fields"}, rsp_result | {8'h0, rsp_ones} | 32'(rsp_timeout), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    #3;
    check("rst_outputs", {cmd_ready, rsp_valid, busy, srd, swr, rsp_timeout}, 32'h0);
    check("rst_addr", {16'h0, saddress}, 32'h0);
    check("rst_wdata", sdata_wr, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_held_ready", 32'(cmd_ready), 32'h0);
    n_reset = 1'b1;
    @(negedge clk);
    check("rst_ready_after_clk", 32'(cmd_ready), 32'h1);
    check("rst_busy_after_clk", 32'(busy), 32'h0);

    // 1: 3*5, done on 4th STATUS read (also the last permitted poll)
    do_job("t1", 24'd3, 24'd5, 4, 0, 32'd15, 24'd4, 1'b0);
    exp_w(ADDR_A1, 32'd3); exp_w(ADDR_A2, 32'd5); exp_w(ADDR_CTRL, 32'h1);
    repeat (4) exp_r(ADDR_STATUS);
    exp_r(ADDR_RESULT); exp_r(ADDR_ONES);
    check_log("t1");

    // 2: full-scale operand
    do_job("t2", 24'hFFFFFF, 24'd2, 1, 0, 32'h01FF_FFFE, 24'd24, 1'b0);
    exp_w(ADDR_A1, 32'h00FF_FFFF); exp_w(ADDR_A2, 32'd2); exp_w(ADDR_CTRL, 32'h1);
    exp_r(ADDR_STATUS); exp_r(ADDR_RESULT); exp_r(ADDR_ONES);
    check_log("t2");

    // 3: peripheral never finishes -> timeout after exactly POLL_MAX reads
    do_job("t3", 24'h10, 24'h20, 0, 0, 32'h0, 24'h0, 1'b1);
    exp_w(ADDR_A1, 32'h10); exp_w(ADDR_A2, 32'h20); exp_w(ADDR_CTRL, 32'h1);
    repeat (4) exp_r(ADDR_STATUS);
    check_log("t3");

    // 4: response held for 10 cycles, new cmd_valid ignored meanwhile
    do_job("t4", 24'h001000, 24'h001000, 2, 10, 32'h0100_0000, 24'd1, 1'b0);
    exp_w(ADDR_A1, 32'h1000); exp_w(ADDR_A2, 32'h1000); exp_w(ADDR_CTRL, 32'h1);
    repeat (2) exp_r(ADDR_STATUS);
    exp_r(ADDR_RESULT); exp_r(ADDR_ONES);
    check_log("t4");

    // 5: reset asserted while swr is high on the A2 write
    m_done_after = 1;
    send_cmd("t5a", 24'hABCDEF, 24'h11);
    n = 0;
    while (!(swr && saddress == ADDR_A2) && n < 100) begin @(negedge clk); n++; end
    check("t5_wr_a2_strobe", 32'(swr && saddress == ADDR_A2), 32'h1);
    #2 n_reset = 1'b0;
    #1;
    check("t5_swr_async", {30'h0, srd, swr}, 32'h0);
    check("t5_addr_async", {16'h0, saddress}, 32'h0);
    check("t5_ctl_async", {29'h0, busy, cmd_ready, rsp_valid}, 32'h0);
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    log_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_no_rsp", {30'h0, rsp_valid, busy}, 32'h0);
    end
    check("t5_no_bus", 32'(log_q.size()), 32'h0);
    do_job("t5b", 24'd7, 24'd9, 2, 0, 32'd63, 24'd6, 1'b0);
    exp_w(ADDR_A1, 32'd7); exp_w(ADDR_A2, 32'd9); exp_w(ADDR_CTRL, 32'h1);
    repeat (2) exp_r(ADDR_STATUS);
    exp_r(ADDR_RESULT); exp_r(ADDR_ONES);
    check_log("t5b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
